// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the ALU scheduler.
package alu_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [3:0] {
    AND  = 4'b0000,
    OR   = 4'b0001,
    XOR  = 4'b0010,
    NOR  = 4'b0011,
    NAND = 4'b0100,
    NOT  = 4'b0101,
    ADD  = 4'b0110,
    SUB  = 4'b0111,
    SLT  = 4'b1000,
    MULT = 4'b1001,
    DIV  = 4'b1010,
    MOD  = 4'b1011,
    SLA  = 4'b1100,
    SRA  = 4'b1101,
    NOP  = 4'b1110,
    RSVD = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sched_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return (op == MULT) || (op == DIV) || (op == MOD);
  endfunction

  // Ops that never reach the ALU and are answered with an error response.
  function automatic logic is_illegal(alu_op_e op, logic [MAX_W-1:0] b);
    return (((op == DIV) || (op == MOD)) && (b == '0)) || (op == NOP) || (op == RSVD);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, shared-ALU and response signals of the ALU scheduler bundled as one interface.
interface alu_scheduler_if #(
  parameter int WIDTH = 32
);

  logic                    req0_valid;
  logic                    req0_ready;
  logic signed [WIDTH-1:0] req0_a;
  logic signed [WIDTH-1:0] req0_b;
  logic [3:0]              req0_opcode;

  logic                    req1_valid;
  logic                    req1_ready;
  logic signed [WIDTH-1:0] req1_a;
  logic signed [WIDTH-1:0] req1_b;
  logic [3:0]              req1_opcode;

  logic signed [WIDTH-1:0] alu_a;
  logic signed [WIDTH-1:0] alu_b;
  logic [3:0]              alu_opcode;
  logic signed [WIDTH-1:0] alu_result;
  logic                    alu_zero;
  logic                    alu_negative;
  logic                    alu_carryout;
  logic                    alu_overflow;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic signed [WIDTH-1:0] rsp_result;
  logic                    rsp_zero;
  logic                    rsp_negative;
  logic                    rsp_carryout;
  logic                    rsp_overflow;
  logic                    rsp_err;
  logic                    busy;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_opcode,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative,
    output rsp_carryout, rsp_overflow, rsp_err, busy,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_opcode,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative,
    input  rsp_carryout, rsp_overflow, rsp_err, busy,
    output rsp_ready
  );

endinterface

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer updated on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic rr_last;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~rr_last;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
  end

  assign grant = {en & req[1] & gnt_id, en & req[0] & ~gnt_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= gnt_id;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one external combinational ALU between two requesters and returns tagged results.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MC_LAT = 3
) (
  input logic             clk,
  input logic             rst_n,
  alu_scheduler_if.master bus
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  sched_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [1:0]              grant;
  logic                    gnt_id;
  logic                    accept;
  logic                    last_issue;

  logic signed [WIDTH-1:0] sel_a;
  logic signed [WIDTH-1:0] sel_b;
  alu_op_e                 sel_op;
  logic                    sel_illegal;

  logic signed [WIDTH-1:0] alu_a_q;
  logic signed [WIDTH-1:0] alu_b_q;
  logic [3:0]              alu_opcode_q;
  logic                    op_id_q;

  logic                    rsp_id_q;
  logic signed [WIDTH-1:0] rsp_result_q;
  logic                    rsp_zero_q;
  logic                    rsp_negative_q;
  logic                    rsp_carryout_q;
  logic                    rsp_overflow_q;
  logic                    rsp_err_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .en     (state_q == IDLE),
    .accept (accept),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign accept         = |grant;

  assign sel_a       = gnt_id ? bus.req1_a : bus.req0_a;
  assign sel_b       = gnt_id ? bus.req1_b : bus.req0_b;
  assign sel_op      = alu_op_e'(gnt_id ? bus.req1_opcode : bus.req0_opcode);
  assign sel_illegal = is_illegal(sel_op, MAX_W'(sel_b));
  assign last_issue  = (state_q == ISSUE) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = sel_illegal ? RESP : ISSUE;
          cnt_d   = is_multicycle(sel_op) ? CNT_W'(MC_LAT - 1) : '0;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The ALU sees real operands only during ISSUE; otherwise it is parked on NOP with zero inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= NOP;
      op_id_q        <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else if (accept) begin
      op_id_q <= gnt_id;
      if (sel_illegal) begin
        rsp_id_q       <= gnt_id;
        rsp_result_q   <= '0;
        rsp_zero_q     <= 1'b0;
        rsp_negative_q <= 1'b0;
        rsp_carryout_q <= 1'b0;
        rsp_overflow_q <= 1'b0;
        rsp_err_q      <= 1'b1;
      end else begin
        alu_a_q      <= sel_a;
        alu_b_q      <= sel_b;
        alu_opcode_q <= sel_op;
      end
    end else if (last_issue) begin
      rsp_id_q       <= op_id_q;
      rsp_result_q   <= bus.alu_result;
      rsp_zero_q     <= bus.alu_zero;
      rsp_negative_q <= bus.alu_negative;
      rsp_carryout_q <= bus.alu_carryout;
      rsp_overflow_q <= bus.alu_overflow;
      rsp_err_q      <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= NOP;
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_opcode   = alu_opcode_q;

  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.busy         = (state_q != IDLE);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_negative = rsp_negative_q;
  assign bus.rsp_carryout = rsp_carryout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU on the shared port, directed scenarios and a randomized scoreboard run.
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int MC_LAT = 3;
  localparam int SH_W   = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic z, n, c, v;
  } res_t;

  typedef struct packed {
    logic id;
    logic err;
    res_t res;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic last_id = 1'b1;
  res_t alu_out;
  exp_t rsp_obs;

  alu_scheduler_if #(.WIDTH(WIDTH)) bus ();

  alu_scheduler #(.WIDTH(WIDTH), .MC_LAT(MC_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t alu_eval(logic [3:0] op, logic signed [WIDTH-1:0] a,
                                    logic signed [WIDTH-1:0] b);
    res_t o;
    logic [WIDTH:0] wide;
    o = '0;
    wide = '0;
    case (op)
      4'd0: o.r = a & b;
      4'd1: o.r = a | b;
      4'd2: o.r = a ^ b;
      4'd3: o.r = ~(a | b);
      4'd4: o.r = ~(a & b);
      4'd5: o.r = ~a;
      4'd6: begin
        wide = {1'b0, a} + {1'b0, b};
        o.r = wide[WIDTH-1:0];
        o.c = wide[WIDTH];
        o.v = (a[WIDTH-1] == b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7: begin
        wide = {1'b0, a} - {1'b0, b};
        o.r = wide[WIDTH-1:0];
        o.c = wide[WIDTH];
        o.v = (a[WIDTH-1] != b[WIDTH-1]) && (o.r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd8: if (a < b) o.r = 1;
      4'd9: o.r = a * b;
      4'd10: if (b != 0) o.r = a / b;
      4'd11: if (b != 0) o.r = a % b;
      4'd12: o.r = a <<< b[SH_W-1:0];
      4'd13: o.r = a >>> b[SH_W-1:0];
      default: o.r = '0;
    endcase
    o.z = (o.r == '0);
    o.n = o.r[WIDTH-1];
    return o;
  endfunction

  function automatic exp_t expect_rsp(logic id, logic [3:0] op, logic signed [WIDTH-1:0] a,
                                      logic signed [WIDTH-1:0] b);
    exp_t e;
    e.id  = id;
    e.err = (((op == 4'd10) || (op == 4'd11)) && (b == 0)) || (op >= 4'd14);
    e.res = e.err ? '0 : alu_eval(op, a, b);
    return e;
  endfunction

  assign alu_out          = alu_eval(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.alu_result   = alu_out.r;
  assign bus.alu_zero     = alu_out.z;
  assign bus.alu_negative = alu_out.n;
  assign bus.alu_carryout = alu_out.c;
  assign bus.alu_overflow = alu_out.v;

  assign rsp_obs = {bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.rsp_zero,
                    bus.rsp_negative, bus.rsp_carryout, bus.rsp_overflow};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_opcode = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_opcode = 4'd0;
    bus.rsp_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    last_id = 1'b1;
  endtask

  // Holds the request until granted; returns one cycle after the accepting edge.
  task automatic wait_accept(input logic id, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      #1;
      ok = (id == 1'b0) ? bus.req0_ready : bus.req1_ready;
      tick();
    end
    if (ok) begin
      drop_req(id);
      last_id = id;
    end
  endtask

  task automatic wait_rsp(input int bound, output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < bound) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000",
               {bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if (bus.alu_opcode !== 4'b1110 || bus.alu_a !== 0 || bus.alu_b !== 0) begin
      errors++;
      $display("FAIL reset_alu got op %b a %h b %h exp 1110/0/0", bus.alu_opcode, bus.alu_a, bus.alu_b);
    end
    checks++;
    if (rsp_obs !== '0) begin
      errors++;
      $display("FAIL reset_rsp got %h exp 0", rsp_obs);
    end
  endtask

  task automatic test_tie();
    exp_t e;
    int lat;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, SUB, 5, 4);
    set_req(1'b1, AND, 1, 0);
    for (int k = 0; k < 3; k++) begin
      logic [1:0] want;
      logic win;
      want = (last_id == 1'b1) ? 2'b10 : 2'b01;
      win  = ~last_id;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== want) begin
        errors++;
        $display("FAIL tie_grant%0d got %b exp %b", k, {bus.req0_ready, bus.req1_ready}, want);
      end
      tick();
      last_id = win;
      if (k == 2) begin
        drop_req(1'b0);
        drop_req(1'b1);
      end
      e = (win == 1'b0) ? expect_rsp(1'b0, SUB, 5, 4) : expect_rsp(1'b1, AND, 1, 0);
      wait_rsp(10, lat);
      checks++;
      if (!bus.rsp_valid || rsp_obs !== e) begin
        errors++;
        $display("FAIL tie_rsp%0d got %h exp %h", k, rsp_obs, e);
      end
      checks++;
      if (bus.req0_ready || bus.req1_ready) begin
        errors++;
        $display("FAIL tie_resp_accept%0d got %b exp 00", k, {bus.req0_ready, bus.req1_ready});
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_add_overflow();
    exp_t e;
    int lat;
    bit ok;
    e = {1'b0, 1'b0, 32'h8000_0000, 4'b0101};
    set_req(1'b0, ADD, 32'h7fff_ffff, 32'd1);
    wait_accept(1'b0, 10, ok);
    wait_rsp(10, lat);
    checks++;
    if (!ok || !bus.rsp_valid || lat != 2) begin
      errors++;
      $display("FAIL add_latency got ok %0d valid %0d lat %0d exp 2", ok, bus.rsp_valid, lat);
    end
    checks++;
    if (rsp_obs !== e) begin
      errors++;
      $display("FAIL add_overflow got %h exp %h", rsp_obs, e);
    end
    finish_rsp();
    checks++;
    if (bus.rsp_valid || bus.busy) begin
      errors++;
      $display("FAIL add_release got valid %0d busy %0d exp 0/0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_mult();
    exp_t e;
    int lat, n;
    bit ok;
    e = {1'b1, 1'b0, 32'd8, 4'b0000};
    set_req(1'b1, MULT, 4, 2);
    wait_accept(1'b1, 10, ok);
    n = 0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.alu_opcode === 4'b1001) n++;
      tick();
      lat++;
    end
    checks++;
    if (!ok || n != MC_LAT || lat != MC_LAT + 1) begin
      errors++;
      $display("FAIL mult_timing got ok %0d hold %0d lat %0d exp %0d/%0d", ok, n, lat, MC_LAT, MC_LAT + 1);
    end
    checks++;
    if (rsp_obs !== e || bus.alu_opcode !== 4'b1110) begin
      errors++;
      $display("FAIL mult_rsp got %h op %b exp %h op 1110", rsp_obs, bus.alu_opcode, e);
    end
    finish_rsp();
  endtask

  task automatic test_div();
    exp_t e;
    int lat;
    bit ok;
    e = {1'b0, 1'b1, 32'd0, 4'b0000};
    set_req(1'b0, DIV, 10, 0);
    wait_accept(1'b0, 10, ok);
    checks++;
    if (!ok || !bus.rsp_valid || bus.alu_opcode !== 4'b1110 || rsp_obs !== e) begin
      errors++;
      $display("FAIL div_zero got ok %0d valid %0d op %b rsp %h exp 1/1/1110/%h",
               ok, bus.rsp_valid, bus.alu_opcode, rsp_obs, e);
    end
    finish_rsp();
    e = {1'b0, 1'b0, 32'd2, 4'b0000};
    set_req(1'b0, DIV, 10, 5);
    wait_accept(1'b0, 10, ok);
    wait_rsp(20, lat);
    checks++;
    if (!ok || lat != MC_LAT + 1 || rsp_obs !== e) begin
      errors++;
      $display("FAIL div_ok got ok %0d lat %0d rsp %h exp lat %0d rsp %h", ok, lat, rsp_obs, MC_LAT + 1, e);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    exp_t e0, e1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    int lat;
    bit ok;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    e0 = expect_rsp(1'b0, XOR, a0, b0);
    e1 = expect_rsp(1'b1, ADD, a1, b1);
    set_req(1'b0, XOR, a0, b0);
    wait_accept(1'b0, 10, ok);
    set_req(1'b1, ADD, a1, b1);
    bus.rsp_ready = 1'b0;
    wait_rsp(10, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!bus.rsp_valid || bus.req1_ready || rsp_obs !== e0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid %0d rdy1 %0d rsp %h exp 1/0/%h",
                 i, bus.rsp_valid, bus.req1_ready, rsp_obs, e0);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready) begin
      errors++;
      $display("FAIL bp_same_cycle got rdy1 1 exp 0");
    end
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (!ok || bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept got ok %0d rdy1 %0d exp 1/1", ok, bus.req1_ready);
    end
    tick();
    drop_req(1'b1);
    last_id = 1'b1;
    wait_rsp(10, lat);
    checks++;
    if (!bus.rsp_valid || lat != 2 || rsp_obs !== e1) begin
      errors++;
      $display("FAIL bp_rsp1 got lat %0d rsp %h exp 2/%h", lat, rsp_obs, e1);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    set_req(1'b0, MOD, 4, 3);
    wait_accept(1'b0, 10, ok);
    tick();
    checks++;
    if (!ok || !bus.busy || bus.alu_opcode !== 4'b1011) begin
      errors++;
      $display("FAIL rmid_issue got ok %0d busy %0d op %b exp 1/1/1011", ok, bus.busy, bus.alu_opcode);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 4'b0 ||
        bus.alu_opcode !== 4'b1110 || bus.alu_a !== 0 || bus.alu_b !== 0 || rsp_obs !== '0) begin
      errors++;
      $display("FAIL rmid_async got ctl %b op %b a %h rsp %h exp 0000/1110/0/0",
               {bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready}, bus.alu_opcode, bus.alu_a, rsp_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_id = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_no_rsp got %0d responses exp 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit pend[2];
    logic [3:0] p_op[2];
    logic [WIDTH-1:0] p_a[2], p_b[2];
    logic [3:0] op;
    logic [WIDTH-1:0] a, b;
    logic r0, r1, win;
    bit acc;
    int served;
    do_reset();
    pend = '{1'b0, 1'b0};
    served = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend[id] && cyc < 450 && $urandom_range(0, 2) == 0) begin
          op = 4'($urandom_range(0, 15));
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
          if ($urandom_range(0, 1) == 0) begin
            a = WIDTH'($urandom_range(0, 40));
            b = (b == '0) ? '0 : WIDTH'($urandom_range(1, 12));
          end
          if (((op == DIV) || (op == MOD)) && b == '1) b = 3;
          p_op[id] = op; p_a[id] = a; p_b[id] = b;
          set_req(1'(id), op, a, b);
          pend[id] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      checks++;
      if ((r0 && r1) || (r0 && !pend[0]) || (r1 && !pend[1]) || ((r0 || r1) && bus.rsp_valid)) begin
        errors++;
        $display("FAIL rand_grant cyc %0d got rdy %b pend %b%b rsp_valid %0d",
                 cyc, {r0, r1}, pend[0], pend[1], bus.rsp_valid);
      end
      acc = r0 || r1;
      win = r1;
      if (acc && pend[0] && pend[1]) begin
        checks++;
        if (win === last_id) begin
          errors++;
          $display("FAIL rand_rr cyc %0d got winner %0d exp %0d", cyc, win, ~last_id);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected cyc %0d got %h exp none", cyc, rsp_obs);
        end else begin
          e = q.pop_front();
          served++;
          if (rsp_obs !== e) begin
            errors++;
            $display("FAIL rand_rsp cyc %0d got %h exp %h", cyc, rsp_obs, e);
          end
        end
      end
      if (acc) begin
        q.push_back(expect_rsp(win, p_op[win], p_a[win], p_b[win]));
        last_id = win;
      end
      tick();
      if (acc) begin
        drop_req(win);
        pend[win] = 1'b0;
      end
    end
    checks++;
    if (pend[0] || pend[1] || q.size() != 0 || served < 20) begin
      errors++;
      $display("FAIL rand_drain got pend %b%b queued %0d served %0d exp 00/0/>=20",
               pend[0], pend[1], q.size(), served);
    end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_add_overflow();
    test_mult();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
